// File: rtl/packet_splitter_var.sv
// packet_splitter_var
//   Width converter: each accepted input word carries 1..SEGMENT_COUNT valid
//   segments, which are appended to a shift-register buffer and drained one
//   segment per pop, each tagged with a packet-end marker.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_full             buffer cannot take a full word this cycle
//   in_shift/in_data    offer an input word
//   in_count/in_end     valid segment count, last valid segment ends packet
//   out_pop             consume head segment
//   out_nempty          head segment valid
//   out_data/out_end    head segment and its packet-end marker
//   fill                buffered segment count
//   pkt_count           buffered end markers
//   err_overflow        sticky: word offered while in_full
//   err_count           sticky: accepted word had an illegal in_count
module packet_splitter_var #(
  parameter int SEGMENT_SIZE    = 4,
  parameter int SEGMENT_COUNT   = 2,
  parameter int BUFFER_SEGMENTS = SEGMENT_COUNT * 2 + 2,
  parameter int MSB_FIRST       = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   in_full,
  input  logic                                   in_shift,
  input  logic [SEGMENT_SIZE*SEGMENT_COUNT-1:0]  in_data,
  input  logic [$clog2(SEGMENT_COUNT+1)-1:0]     in_count,
  input  logic                                   in_end,
  input  logic                                   out_pop,
  output logic                                   out_nempty,
  output logic [SEGMENT_SIZE-1:0]                out_data,
  output logic                                   out_end,
  output logic [$clog2(BUFFER_SEGMENTS+1)-1:0]   fill,
  output logic [$clog2(BUFFER_SEGMENTS+1)-1:0]   pkt_count,
  output logic                                   err_overflow,
  output logic                                   err_count
);

  localparam int WORD_W = SEGMENT_SIZE * SEGMENT_COUNT;
  localparam int CNT_W  = $clog2(SEGMENT_COUNT + 1);
  localparam int FILL_W = $clog2(BUFFER_SEGMENTS + 1);
  localparam logic [FILL_W-1:0] FULL_LIMIT = FILL_W'(BUFFER_SEGMENTS - SEGMENT_COUNT);
  localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
  localparam logic [CNT_W-1:0]  MAX_COUNT  = CNT_W'(SEGMENT_COUNT);

  logic [SEGMENT_SIZE-1:0]    data_q [BUFFER_SEGMENTS];
  logic [SEGMENT_SIZE-1:0]    data_d [BUFFER_SEGMENTS];
  logic [BUFFER_SEGMENTS-1:0] end_q;
  logic [BUFFER_SEGMENTS-1:0] end_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [FILL_W-1:0]          pkt_q, pkt_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_cnt_q, err_cnt_d;

  logic                       full_s;
  logic                       pop_s;
  logic                       accept_s;
  logic                       count_ok_s;
  logic [CNT_W-1:0]           n_s;
  logic [FILL_W-1:0]          base_s;
  logic [SEGMENT_SIZE-1:0]    seg_s [SEGMENT_COUNT];
  logic [SEGMENT_SIZE-1:0]    shd_data_s [BUFFER_SEGMENTS];
  logic [BUFFER_SEGMENTS-1:0] shd_end_s;

  // Handshake decode; in_full looks only at registered fill.
  always_comb begin
    full_s     = (fill_q > FULL_LIMIT);
    pop_s      = out_pop && (fill_q != {FILL_W{1'b0}});
    accept_s   = in_shift && !full_s;
    count_ok_s = (in_count != {CNT_W{1'b0}}) && (in_count <= MAX_COUNT);
    n_s        = (accept_s && count_ok_s) ? in_count : {CNT_W{1'b0}};
    // Pop is applied before the write, so new segments land one slot lower.
    base_s     = fill_q - (pop_s ? FILL_ONE : {FILL_W{1'b0}});
  end

  // Slice the input word into segments in output order.
  always_comb begin
    for (int j = 0; j < SEGMENT_COUNT; j++) begin
      if (MSB_FIRST != 0) begin
        seg_s[j] = in_data[WORD_W-1-j*SEGMENT_SIZE -: SEGMENT_SIZE];
      end else begin
        seg_s[j] = in_data[j*SEGMENT_SIZE +: SEGMENT_SIZE];
      end
    end
  end

  // Buffer contents after an optional pop; the vacated top entry is cleared.
  always_comb begin
    for (int i = 0; i < BUFFER_SEGMENTS - 1; i++) begin
      shd_data_s[i] = pop_s ? data_q[i+1] : data_q[i];
      shd_end_s[i]  = pop_s ? end_q[i+1]  : end_q[i];
    end
    shd_data_s[BUFFER_SEGMENTS-1] = pop_s ? {SEGMENT_SIZE{1'b0}} : data_q[BUFFER_SEGMENTS-1];
    shd_end_s[BUFFER_SEGMENTS-1]  = pop_s ? 1'b0 : end_q[BUFFER_SEGMENTS-1];
  end

  // Overlay the accepted segments at base_s .. base_s+n_s-1.
  always_comb begin
    logic                    sel;
    logic                    hit;
    logic [SEGMENT_SIZE-1:0] wr_data;
    logic                    wr_end;
    for (int i = 0; i < BUFFER_SEGMENTS; i++) begin
      hit     = 1'b0;
      wr_data = {SEGMENT_SIZE{1'b0}};
      wr_end  = 1'b0;
      for (int j = 0; j < SEGMENT_COUNT; j++) begin
        sel     = (j < int'(n_s)) && ((int'(base_s) + j) == i);
        hit     = hit | sel;
        wr_data = sel ? seg_s[j] : wr_data;
        // Only the last written segment carries in_end.
        wr_end  = sel ? ((j == int'(n_s) - 1) ? in_end : 1'b0) : wr_end;
      end
      data_d[i] = hit ? wr_data : shd_data_s[i];
      end_d[i]  = hit ? wr_end  : shd_end_s[i];
    end
  end

  // Occupancy, packet count and sticky error next-state.
  always_comb begin
    fill_d = fill_q + FILL_W'(n_s) - (pop_s ? FILL_ONE : {FILL_W{1'b0}});
    if ((accept_s && count_ok_s && in_end) && !(pop_s && end_q[0])) begin
      pkt_d = pkt_q + FILL_ONE;
    end else if (!(accept_s && count_ok_s && in_end) && (pop_s && end_q[0])) begin
      pkt_d = pkt_q - FILL_ONE;
    end else begin
      pkt_d = pkt_q;
    end
    err_ovf_d = err_ovf_q | (in_shift && full_s);
    err_cnt_d = err_cnt_q | (accept_s && !count_ok_s);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUFFER_SEGMENTS; i++) begin
        data_q[i] <= {SEGMENT_SIZE{1'b0}};
      end
      end_q     <= {BUFFER_SEGMENTS{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      pkt_q     <= {FILL_W{1'b0}};
      err_ovf_q <= 1'b0;
      err_cnt_q <= 1'b0;
    end else begin
      for (int i = 0; i < BUFFER_SEGMENTS; i++) begin
        data_q[i] <= data_d[i];
      end
      end_q     <= end_d;
      fill_q    <= fill_d;
      pkt_q     <= pkt_d;
      err_ovf_q <= err_ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_full      = full_s;
  assign out_nempty   = (fill_q != {FILL_W{1'b0}});
  assign out_data     = data_q[0];
  assign out_end      = end_q[0];
  assign fill         = fill_q;
  assign pkt_count    = pkt_q;
  assign err_overflow = err_ovf_q;
  assign err_count    = err_cnt_q;

endmodule

// File: doc/packet_splitter_var.md
# packet_splitter_var

Width converter that turns wide input words carrying a variable number of valid segments (1..SEGMENT_COUNT) into a stream of single segments, each with a packet-end marker. It is the parametrised successor of the fixed-count splitter used between wide serialiser/framing logic and narrow link or output stages. New relative to that block:
- per-word segment count
- selectable segment order
- configurable buffer depth
- buffered-packet counter
- sticky error flags
- asynchronous reset

## Interface
Parameters:
- SEGMENT_SIZE, 4, bits per output segment
- SEGMENT_COUNT, 2, maximum segments per input word (≥1)
- BUFFER_SEGMENTS, SEGMENT_COUNT*2+2, buffer depth in segments (≥SEGMENT_COUNT)
- MSB_FIRST, 0, 0: segment 0 = in_data[SEGMENT_SIZE-1:0]; 1: segment 0 = top SEGMENT_SIZE bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_full  out  1  cannot accept a word this cycle
- in_shift  in  1  offer input word
- in_data  in  SEGMENT_SIZE*SEGMENT_COUNT  input word
- in_count  in  $clog2(SEGMENT_COUNT+1)  number of valid segments in in_data
- in_end  in  1  last valid segment of this word ends a packet
- out_pop  in  1  consume head segment
- out_nempty  out  1  head segment valid
- out_data  out  SEGMENT_SIZE  head segment
- out_end  out  1  head segment ends a packet
- fill  out  $clog2(BUFFER_SEGMENTS+1)  buffered segment count
- pkt_count  out  $clog2(BUFFER_SEGMENTS+1)  buffered end markers (complete packets)
- err_overflow  out  1  sticky: in_shift while in_full
- err_count  out  1  sticky: in_shift accepted with in_count==0 or >SEGMENT_COUNT

## Operation
- Buffer: shift register of BUFFER_SEGMENTS entries (data, end). The head is entry 0.
- in_full = (fill > BUFFER_SEGMENTS − SEGMENT_COUNT). It depends only on registered fill and has no combinational path from out_pop.
- The buffer accepts a word when in_shift && !in_full.
- The buffer pops a segment when out_pop && out_nempty. A pop on empty is ignored and raises no flag.
- out_nempty = (fill ≠ 0). out_data/out_end = entry 0.
- Order within a word:
  - MSB_FIRST=0: the first in_count segments from the LSB end are written in ascending order.
  - MSB_FIRST=1: the first in_count segments from the MSB end are written, top first.
  - Unused segments are discarded.
- An accepted word writes its valid segments at index fill − pop, then consecutive indices. The end flag of the last written segment = in_end; all other written end flags = 0.
- A pop shifts every entry down by one. The top entry is cleared to data 0 / end 0.
- fill_next = fill + n − pop, where n is the valid segment count of an accepted word (0 if no word is accepted).
- Invalid in_count (0 or >SEGMENT_COUNT) on an accepted word:
  - nothing is written, so n = 0
  - in_end is discarded
  - err_count is set
- in_shift while in_full:
  - the word is dropped and err_overflow is set
  - all other state is unchanged
- pkt_count:
  - +1 on an accepted valid word with in_end=1
  - −1 on a pop with out_end=1
  - both in the same cycle: unchanged
- Error flags are cleared only by reset.

## Timing
- Asynchronous reset (rst_n=0) immediately forces:
  - fill=0, pkt_count=0, all entries 0, errors 0
  - outputs: in_full=0, out_nempty=0, out_data=0, out_end=0, err_*=0
- Reset mid-packet discards all buffered segments. There is no partial-packet recovery; the first word after release starts clean.
- Deassertion is sampled at the next rising edge. The first accept is possible on the first edge with rst_n=1.
- Latency: a word accepted at edge k is visible at the head after edge k if the buffer was empty (out_nempty=1, out_data=segment 0).
- Throughput: one pop per cycle with no bubbles. Pop and shift in the same cycle are both honoured, with pop applied first for indexing.
- Boundaries:
  - fill = BUFFER_SEGMENTS − SEGMENT_COUNT still accepts a full word.
  - fill = BUFFER_SEGMENTS is reachable.
  - fill never exceeds BUFFER_SEGMENTS and never underflows.

## Test plan
Defaults (SEGMENT_SIZE=4, SEGMENT_COUNT=2, BUFFER_SEGMENTS=6) unless stated.
- Full word: shift in_data=8'hA5, in_count=2, in_end=1 -> next cycle out_data=5, out_end=0, fill=2, pkt_count=1; pop -> out_data=A, out_end=1; pop -> out_nempty=0, pkt_count=0.
- Partial word: shift 8'h3C, in_count=1, in_end=1 -> fill=1, out_data=C, out_end=1; the 3 is never output.
- Fill/overflow: three full words without pop -> fill 2, 4, 6; in_full=1 after the third; fourth shift dropped, fill=6, err_overflow=1 until reset.
- Simultaneous: at fill=4, pop and shift 8'h21 (count 2) in one cycle -> fill=5; order preserved, 1 then 2 after the remaining three entries.
- Invalid count: shift in_count=0, in_end=1 -> fill, pkt_count unchanged, err_count=1.
- Async reset with MSB_FIRST=1: shift 8'hA5 (count 2) -> A then 5; pull rst_n low between edges at fill=1 -> out_nempty=0, out_data=0, fill=0 immediately.
